// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier datapath: controller state
// encoding and the vector/matrix sizes derived from L_RAM_SIZE.
package mm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_FLUSH,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   // Number of elements in one vector: 2^L
   function automatic int unsigned vector_size(input int unsigned l);
      return 32'd1 << l;
   endfunction

   // Number of elements in one square matrix: 2^(2L)
   function automatic int unsigned matrix_size(input int unsigned l);
      return 32'd1 << (2 * l);
   endfunction

endpackage

// File: rtl/mm_wr_addr_gen.sv
// Beat counter to operand BRAM address mapping.
// Build option MM_LOADER_TRANSPOSE_EN: store matrix B column-major
// (A stays row-major); without it every beat lands at its own index.
module mm_wr_addr_gen #(
   parameter int unsigned L_RAM_SIZE = 3
) (
   input  logic [2*L_RAM_SIZE:0] cnt,
   output logic [2*L_RAM_SIZE:0] addr
);

`ifdef MM_LOADER_TRANSPOSE_EN
   import mm_pkg::*;

   localparam int unsigned AW = 2 * L_RAM_SIZE + 1;
   localparam int unsigned MS = matrix_size(L_RAM_SIZE);
   localparam int unsigned VS = vector_size(L_RAM_SIZE);

   logic [AW-1:0] k;
   logic [AW-1:0] r;
   logic [AW-1:0] c;

   // B beats: k = cnt-MS, row = k/VS, col = k%VS, written at MS + col*VS + row
   always_comb begin
      k    = cnt - AW'(MS);
      r    = k >> L_RAM_SIZE;
      c    = k & AW'(VS - 1);
      addr = cnt;
      if (cnt >= AW'(MS)) begin
         addr = AW'(MS) + (c << L_RAM_SIZE) + r;
      end
   end
`else
   // Identity mapping: beat index is the address
   always_comb begin
      addr = cnt;
   end
`endif

endmodule

// File: rtl/mm_stream_loader.sv
// Stream-to-BRAM operand loader for the matrix multiplier: accepts one frame
// of A then B words, writes them to BRAM, starts the core, waits for done.
// Build option MM_LOADER_TRANSPOSE_EN selects column-major storage of B.
module mm_stream_loader
   import mm_pkg::*;
#(
   parameter int unsigned L_RAM_SIZE = 3,
   parameter int unsigned BITWIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BITWIDTH-1:0]   s_data,
   input  logic                  s_last,
   output logic [2*L_RAM_SIZE:0] bram_addr,
   output logic [BITWIDTH-1:0]   bram_wrdata,
   output logic                  bram_we,
   output logic                  mm_start,
   input  logic                  mm_done,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int unsigned AW = 2 * L_RAM_SIZE + 1;
   localparam int unsigned MS = matrix_size(L_RAM_SIZE);
   localparam logic [AW-1:0] LAST_CNT = AW'(2 * MS - 1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_nxt;
   logic [AW-1:0] wr_addr;
   logic          beat;
   logic          loading;
   logic          last_slot;

   assign beat      = s_valid && s_ready;
   assign loading   = (state == S_IDLE) || (state == S_LOAD);
   assign last_slot = (cnt == LAST_CNT);

   mm_wr_addr_gen #(
      .L_RAM_SIZE(L_RAM_SIZE)
   ) u_addr_gen (
      .cnt (cnt),
      .addr(wr_addr)
   );

   // State and beat counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state: IDLE and LOAD share the beat checks so a one-word frame is judged like any other
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_LOAD: begin
            if (beat) begin
               if (last_slot)   state_nxt = s_last ? S_FLUSH : S_DRAIN;
               else if (s_last) state_nxt = S_IDLE;
               else             state_nxt = S_LOAD;
            end
         end
         S_DRAIN: if (beat && s_last) state_nxt = S_IDLE;
         S_FLUSH: state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (mm_done) state_nxt = S_DONE;
         S_DONE:  if (!mm_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counter: cleared on entry to IDLE, saturates at the final slot
   always_comb begin
      cnt_nxt = cnt;
      if (state_nxt == S_IDLE)                 cnt_nxt = '0;
      else if (loading && beat && !last_slot)  cnt_nxt = cnt + 1'b1;
   end

   // Moore outputs decoded from state
   always_comb begin
      s_ready  = 1'b0;
      busy     = 1'b1;
      mm_start = 1'b0;
      case (state)
         S_IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
         end
         S_LOAD, S_DRAIN: s_ready  = 1'b1;
         S_START:         mm_start = 1'b1;
         default: ;
      endcase
   end

   // Registered BRAM write port; address/data hold when no word is written
   always_ff @(posedge clk) begin
      if (reset) begin
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_wrdata <= '0;
      end else begin
         bram_we <= loading && beat;
         if (loading && beat) begin
            bram_addr   <= wr_addr;
            bram_wrdata <= s_data;
         end
      end
   end

   // Registered status pulses, one cycle after the deciding sample
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= (state == S_WAIT) && mm_done;
         frame_err  <= beat && s_last && ((loading && !last_slot) || (state == S_DRAIN));
      end
   end

endmodule

// File: tb/tb_mm_stream_loader.sv
// Self-checking bench for mm_stream_loader at L_RAM_SIZE=1 (MS=4, 8-word frames).
// Honours MM_LOADER_TRANSPOSE_EN in its reference address model.
module tb_mm_stream_loader;

   localparam int L  = 1;
   localparam int BW = 32;
   localparam int VS = 2;
   localparam int MS = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [BW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic [AW-1:0] bram_addr;
   logic [BW-1:0] bram_wrdata;
   logic          bram_we;
   logic          mm_start;
   logic          mm_done = 1'b0;
   logic          busy;
   logic          frame_done;
   logic          frame_err;

   mm_stream_loader #(
      .L_RAM_SIZE(L),
      .BITWIDTH(BW)
   ) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_we(bram_we),
      .mm_start(mm_start), .mm_done(mm_done), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   int wr_addr_q[$];
   int wr_data_q[$];
   int wr_cyc_q[$];
   int n_start = 0, n_fdone = 0, n_ferr = 0;
   int start_cyc = 0, fdone_cyc = 0, ferr_cyc = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (bram_we) begin
            wr_addr_q.push_back(int'(bram_addr));
            wr_data_q.push_back(int'(bram_wrdata));
            wr_cyc_q.push_back(cyc);
         end
         if (mm_start)   begin n_start++; start_cyc = cyc; end
         if (frame_done) begin n_fdone++; fdone_cyc = cyc; end
         if (frame_err)  begin n_ferr++;  ferr_cyc  = cyc; end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int exp_addr(input int i);
      int k;
      k = i - MS;
`ifdef MM_LOADER_TRANSPOSE_EN
      if (i >= MS) return MS + (k % VS) * VS + k / VS;
`endif
      return i;
   endfunction

   task automatic clear_log();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      n_start = 0; n_fdone = 0; n_ferr = 0;
   endtask

   // gap_mode: 0 none, 1 alternating 0/2 idle cycles, 2 random 0..3
   task automatic run_frame(input string name, input int n, input int gap_mode,
                            input bit seq_data, input int done_len);
      int d[$];
      int bcyc[$];
      int gap, w, m, dcyc;
      bit exp_ok;
      clear_log();
      for (int i = 0; i < n; i++) d.push_back(seq_data ? i + 1 : int'($urandom));
      for (int i = 0; i < n; i++) begin
         gap = (gap_mode == 1) ? ((i % 2 == 1) ? 2 : 0) :
               (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
         repeat (gap) begin
            s_valid = 1'b0; s_last = 1'($urandom); s_data = $urandom;
            tick();
         end
         s_valid = 1'b1; s_data = d[i]; s_last = (i == n - 1);
         w = 0;
         while (!s_ready && w < 50) begin tick(); w++; end
         n_checks++;
         if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_at_beat%0d: got %b want 1", name, i, s_ready);
         end
         bcyc.push_back(cyc);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0;

      exp_ok = (n == 2 * MS);
      if (exp_ok) begin
         w = 0;
         while (n_start == 0 && w < 10) begin tick(); w++; end
         n_checks++;
         if (n_start != 1) begin
            n_fail++; $display("FAIL %s start_count: got %0d want 1", name, n_start);
         end
         n_checks++;
         if (start_cyc - bcyc[n-1] != 2) begin
            n_fail++; $display("FAIL %s start_latency: got %0d want 2", name, start_cyc - bcyc[n-1]);
         end
         tick();
         repeat ($urandom_range(0, 3)) tick();
         n_checks++;
         if (s_ready !== 1'b0 || busy !== 1'b1 || n_fdone != 0) begin
            n_fail++; $display("FAIL %s wait_state: ready=%b busy=%b fdone=%0d want 0 1 0",
                               name, s_ready, busy, n_fdone);
         end
         mm_done = 1'b1; dcyc = cyc;
         repeat (done_len) tick();
         n_checks++;
         if (s_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s done_hold: ready=%b busy=%b want 0 1", name, s_ready, busy);
         end
         mm_done = 1'b0;
         w = 0;
         while (busy && w < 10) begin tick(); w++; end
         n_checks++;
         if (n_fdone != 1) begin
            n_fail++; $display("FAIL %s frame_done_count: got %0d want 1", name, n_fdone);
         end
         n_checks++;
         if (fdone_cyc - dcyc != 1) begin
            n_fail++; $display("FAIL %s frame_done_latency: got %0d want 1", name, fdone_cyc - dcyc);
         end
         n_checks++;
         if (busy !== 1'b0 || s_ready !== 1'b1 || n_ferr != 0) begin
            n_fail++; $display("FAIL %s back_to_idle: busy=%b ready=%b err=%0d want 0 1 0",
                               name, busy, s_ready, n_ferr);
         end
      end else begin
         repeat (3) tick();
         n_checks++;
         if (n_ferr != 1) begin
            n_fail++; $display("FAIL %s frame_err_count: got %0d want 1", name, n_ferr);
         end
         n_checks++;
         if (ferr_cyc - bcyc[n-1] != 1) begin
            n_fail++; $display("FAIL %s frame_err_latency: got %0d want 1", name, ferr_cyc - bcyc[n-1]);
         end
         n_checks++;
         if (n_start != 0 || n_fdone != 0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s err_idle: start=%0d fdone=%0d busy=%b ready=%b want 0 0 0 1",
                               name, n_start, n_fdone, busy, s_ready);
         end
      end

      m = (n < 2 * MS) ? n : 2 * MS;
      n_checks++;
      if (wr_addr_q.size() != m) begin
         n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), m);
      end
      for (int j = 0; j < m && j < wr_addr_q.size(); j++) begin
         n_checks++;
         if (wr_addr_q[j] != exp_addr(j) || wr_data_q[j] != d[j] || wr_cyc_q[j] - bcyc[j] != 1) begin
            n_fail++;
            $display("FAIL %s write%0d: addr=%0d data=%h lat=%0d want addr=%0d data=%h lat=1",
                     name, j, wr_addr_q[j], wr_data_q[j], wr_cyc_q[j] - bcyc[j], exp_addr(j), d[j]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (bram_addr !== '0 || bram_wrdata !== '0 || bram_we !== 1'b0 || mm_start !== 1'b0 ||
          frame_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s outputs: addr=%0d data=%h we=%b start=%b done=%b err=%b busy=%b ready=%b want 0 0 0 0 0 0 0 1",
                  name, bram_addr, bram_wrdata, bram_we, mm_start, frame_done, frame_err, busy, s_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset_held");
      reset = 1'b0;
      tick();
      check_reset_outputs("after_reset");
   endtask

   task automatic test_nominal();
      run_frame("nominal", 2 * MS, 0, 1'b1, 5);
   endtask

   task automatic test_early_last();
      run_frame("early_last", 3, 0, 1'b0, 1);
      run_frame("after_early", 2 * MS, 0, 1'b0, 2);
      run_frame("single_beat", 1, 0, 1'b0, 1);
   endtask

   task automatic test_missing_last();
      run_frame("missing_last", 10, 0, 1'b0, 1);
      run_frame("after_missing", 2 * MS, 0, 1'b0, 1);
   endtask

   task automatic test_gaps();
      run_frame("gaps_alt", 2 * MS, 1, 1'b1, 3);
      run_frame("gaps_rand", 2 * MS, 2, 1'b0, 2);
   endtask

   task automatic test_reset_mid_frame();
      clear_log();
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
         tick();
      end
      s_valid = 1'b0;
      reset = 1'b1;
      tick();
      check_reset_outputs("mid_reset");
      reset = 1'b0;
      repeat (6) tick();
      n_checks++;
      if (n_start != 0 || n_ferr != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_quiet: start=%0d err=%0d busy=%b want 0 0 0", n_start, n_ferr, busy);
      end
      run_frame("after_mid_reset", 2 * MS, 0, 1'b1, 2);
   endtask

   task automatic test_transpose();
      run_frame("transpose_layout", 2 * MS, 0, 1'b1, 1);
   endtask

   task automatic test_back_to_back();
      int lens[5] = '{2 * MS, 5, 2 * MS, 11, 2 * MS};
      for (int i = 0; i < 5; i++) run_frame($sformatf("b2b%0d", i), lens[i], 2, 1'b0, int'($urandom_range(1, 4)));
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_early_last();
      test_missing_last();
      test_gaps();
      test_reset_mid_frame();
      test_transpose();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
